// File: rtl/gpio_pad_seq_pkg.sv
// gpio_pad_pkg: shared types and constants for the GPIO pad sequencer.
//   pad_cfg_t   - packed pad configuration {outenb, inenb, mode1, mode0}
//   state_e     - per-channel sequencer state (ST_STEADY / ST_DEAD)
//   SAFE_*      - high-Z configuration held during dead time and after reset
//   target_cfg  - maps GPIO controls (outenb, pu, pd) to the requested pad configuration
//   target_out  - maps GPIO controls (out, pu, pd) to the requested pad data
package gpio_pad_pkg;

  typedef enum logic {
    ST_STEADY = 1'b0,
    ST_DEAD   = 1'b1
  } state_e;

  typedef struct packed {
    logic outenb;
    logic inenb;
    logic mode1;
    logic mode0;
  } pad_cfg_t;

  localparam logic SAFE_OUTENB = 1'b1;
  localparam logic SAFE_INENB  = 1'b0;
  localparam logic SAFE_MODE1  = 1'b0;
  localparam logic SAFE_MODE0  = 1'b1;
  localparam logic SAFE_OUT    = 1'b0;

  localparam pad_cfg_t SAFE_CFG = '{
    outenb: SAFE_OUTENB,
    inenb:  SAFE_INENB,
    mode1:  SAFE_MODE1,
    mode0:  SAFE_MODE0
  };

  // A pull request turns an input pad into a weakly driven one, so it clears outenb_t.
  function automatic pad_cfg_t target_cfg(logic outenb, logic pu, logic pd);
    pad_cfg_t cfg;
    cfg.outenb = outenb & ~pu & ~pd;
    cfg.inenb  = ~outenb;
    cfg.mode1  = ~cfg.outenb;
    cfg.mode0  = outenb;
    return cfg;
  endfunction

  // Pull-up wins over pull-down when both are requested.
  function automatic logic target_out(logic out, logic pu, logic pd);
    return pu ? 1'b1 : (pd ? 1'b0 : out);
  endfunction

endpackage

// File: rtl/gpio_pad_seq_if.sv
// gpio_pad_seq_if: bundle of per-channel GPIO control, pad control and input return signals.
//   gpio_out/gpio_outenb/gpio_pu/gpio_pd - requested GPIO controls (controller side)
//   pad_in                               - raw asynchronous pad input (pad ring side)
//   gpio_*_pad                           - registered pad controls (sequencer side)
//   gpio_in, busy                        - returned input and dead-time status (sequencer side)
// Modports: master = controller/pad ring driving requests, slave = the sequencer.
interface gpio_pad_seq_if #(
  parameter int unsigned NUM_GPIO = 38
) ();

  logic [NUM_GPIO-1:0] gpio_out;
  logic [NUM_GPIO-1:0] gpio_outenb;
  logic [NUM_GPIO-1:0] gpio_pu;
  logic [NUM_GPIO-1:0] gpio_pd;
  logic [NUM_GPIO-1:0] pad_in;
  logic [NUM_GPIO-1:0] gpio_out_pad;
  logic [NUM_GPIO-1:0] gpio_outenb_pad;
  logic [NUM_GPIO-1:0] gpio_inenb_pad;
  logic [NUM_GPIO-1:0] gpio_mode1_pad;
  logic [NUM_GPIO-1:0] gpio_mode0_pad;
  logic [NUM_GPIO-1:0] gpio_in;
  logic [NUM_GPIO-1:0] busy;

  modport master (
    output gpio_out, gpio_outenb, gpio_pu, gpio_pd, pad_in,
    input  gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad, gpio_mode1_pad, gpio_mode0_pad,
    input  gpio_in, busy
  );

  modport slave (
    input  gpio_out, gpio_outenb, gpio_pu, gpio_pd, pad_in,
    output gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad, gpio_mode1_pad, gpio_mode0_pad,
    output gpio_in, busy
  );

endinterface

// File: rtl/gpio_pad_seq_chan.sv
// gpio_pad_chan: one pad channel of the GPIO pad sequencer.
//   clk, rst                          - clock, asynchronous active-high reset
//   gpio_out/outenb/pu/pd             - requested GPIO controls
//   pad_in                            - raw asynchronous pad input
//   out_pad/outenb_pad/inenb_pad/
//   mode1_pad/mode0_pad               - registered pad controls
//   gpio_in                           - synchronised (optionally debounced) pad input
//   busy                              - channel is holding the safe high-Z dead time
// A configuration change away from SAFE is routed through DEAD_CYCLES cycles of SAFE so
// the pad never switches directly between two drive modes.
module gpio_pad_chan
  import gpio_pad_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned DEB_CYCLES  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic gpio_out,
  input  logic gpio_outenb,
  input  logic gpio_pu,
  input  logic gpio_pd,
  input  logic pad_in,
  output logic out_pad,
  output logic outenb_pad,
  output logic inenb_pad,
  output logic mode1_pad,
  output logic mode0_pad,
  output logic gpio_in,
  output logic busy
);

  // Counter only needs to hold DEAD_CYCLES-1.
  localparam int unsigned DW = (DEAD_CYCLES > 2) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);
  localparam bit DIRECT = (DEAD_CYCLES == 0);

  pad_cfg_t      cfg_t;
  logic          out_t;
  state_e        state;
  pad_cfg_t      cfg_a;    // configuration currently applied in STEADY
  pad_cfg_t      cfg_lat;  // target latched while waiting in DEAD
  pad_cfg_t      pad_cfg;  // registered pad configuration outputs
  logic [DW-1:0] dead_cnt;

  assign cfg_t = target_cfg(gpio_outenb, gpio_pu, gpio_pd);
  assign out_t = target_out(gpio_out, gpio_pu, gpio_pd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_STEADY;
      cfg_a    <= SAFE_CFG;
      cfg_lat  <= SAFE_CFG;
      pad_cfg  <= SAFE_CFG;
      out_pad  <= SAFE_OUT;
      busy     <= 1'b0;
      dead_cnt <= '0;
    end else begin
      case (state)
        ST_STEADY: begin
          if (cfg_t == cfg_a) begin
            out_pad <= out_t;
          end else if (DIRECT || (cfg_t == SAFE_CFG)) begin
            // Moving to SAFE is itself harmless, so no dead time is needed.
            cfg_a   <= cfg_t;
            pad_cfg <= cfg_t;
            out_pad <= out_t;
          end else begin
            state    <= ST_DEAD;
            cfg_lat  <= cfg_t;
            dead_cnt <= DEAD_LOAD;
            pad_cfg  <= SAFE_CFG;
            out_pad  <= SAFE_OUT;
            busy     <= 1'b1;
          end
        end
        ST_DEAD: begin
          // A new target restarts the full window, even on the last cycle.
          if (cfg_t != cfg_lat) begin
            cfg_lat  <= cfg_t;
            dead_cnt <= DEAD_LOAD;
          end else if (dead_cnt == '0) begin
            state   <= ST_STEADY;
            cfg_a   <= cfg_t;
            pad_cfg <= cfg_t;
            out_pad <= out_t;
            busy    <= 1'b0;
          end else begin
            dead_cnt <= dead_cnt - DW'(1);
          end
        end
        default: state <= ST_STEADY;
      endcase
    end
  end

  assign outenb_pad = pad_cfg.outenb;
  assign inenb_pad  = pad_cfg.inenb;
  assign mode1_pad  = pad_cfg.mode1;
  assign mode0_pad  = pad_cfg.mode0;

  logic sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
    end
  end

  if (DEB_CYCLES == 0) begin : g_sync
    assign gpio_in = sync2;
  end else begin : g_deb
    localparam int unsigned BW = $clog2(DEB_CYCLES + 1);
    localparam logic [BW-1:0] DEB_LAST = BW'(DEB_CYCLES - 1);

    logic [BW-1:0] deb_cnt;
    logic          deb_val;

    // The update happens on the edge where the count would reach DEB_CYCLES, so gpio_in
    // follows DEB_CYCLES cycles after the synchroniser output first differs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_cnt <= '0;
        deb_val <= 1'b0;
      end else if (sync2 != deb_val) begin
        if (deb_cnt == DEB_LAST) begin
          deb_val <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + BW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end

    assign gpio_in = deb_val;
  end

endmodule

// File: rtl/gpio_pad_seq.sv
// gpio_pad_seq: multi-channel GPIO-to-pad converter with dead-time sequencing.
//   wb_clk_i - single clock
//   wb_rst_i - asynchronous active-high reset
//   bus      - gpio_pad_seq_if slave: GPIO requests and pad_in in; pad controls,
//              gpio_in and busy out (all NUM_GPIO wide)
// Every channel is an independent gpio_pad_chan instance.
module gpio_pad_seq #(
  parameter int unsigned NUM_GPIO    = 38,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned DEB_CYCLES  = 0
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  gpio_pad_seq_if.slave  bus
);

  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_chan
    gpio_pad_chan #(
      .DEAD_CYCLES (DEAD_CYCLES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_chan (
      .clk         (wb_clk_i),
      .rst         (wb_rst_i),
      .gpio_out    (bus.gpio_out[i]),
      .gpio_outenb (bus.gpio_outenb[i]),
      .gpio_pu     (bus.gpio_pu[i]),
      .gpio_pd     (bus.gpio_pd[i]),
      .pad_in      (bus.pad_in[i]),
      .out_pad     (bus.gpio_out_pad[i]),
      .outenb_pad  (bus.gpio_outenb_pad[i]),
      .inenb_pad   (bus.gpio_inenb_pad[i]),
      .mode1_pad   (bus.gpio_mode1_pad[i]),
      .mode0_pad   (bus.gpio_mode0_pad[i]),
      .gpio_in     (bus.gpio_in[i]),
      .busy        (bus.busy[i])
    );
  end

endmodule

// File: tb/tb_gpio_pad_seq.sv
// tb_gpio_pad_seq: drives two sequencer instances (dead time 2 / debounce 4, and
// dead time 0 / sync only) with directed and random GPIO requests and compares every
// output each cycle against a behavioural model of the pad sequencing rules.
module tb_gpio_pad_seq;

  localparam int N    = 8;
  localparam int NDUT = 2;
  localparam logic [3:0] SAFE = 4'b1001;  // {outenb, inenb, mode1, mode0}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_out = '0, req_oe = '1, req_pu = '0, req_pd = '0, req_pin = '0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpio_pad_seq_if #(.NUM_GPIO(N)) if_a ();
  gpio_pad_seq_if #(.NUM_GPIO(N)) if_b ();

  assign if_a.gpio_out = req_out;  assign if_b.gpio_out = req_out;
  assign if_a.gpio_outenb = req_oe;  assign if_b.gpio_outenb = req_oe;
  assign if_a.gpio_pu = req_pu;  assign if_b.gpio_pu = req_pu;
  assign if_a.gpio_pd = req_pd;  assign if_b.gpio_pd = req_pd;
  assign if_a.pad_in = req_pin;  assign if_b.pad_in = req_pin;

  gpio_pad_seq #(.NUM_GPIO(N), .DEAD_CYCLES(2), .DEB_CYCLES(4)) dut_a (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (if_a)
  );

  gpio_pad_seq #(.NUM_GPIO(N), .DEAD_CYCLES(0), .DEB_CYCLES(0)) dut_b (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (if_b)
  );

  // Reference model state
  int         dead_p [NDUT];
  int         deb_p  [NDUT];
  logic [3:0] m_app  [NDUT][N];  // config the pad settles on
  logic [3:0] m_pend [NDUT][N];  // config being waited for in the safe window
  logic [3:0] m_show [NDUT][N];  // config visible on the pad
  logic       m_out  [NDUT][N];
  int         m_left [NDUT][N];  // safe cycles still to show
  logic       m_s1   [NDUT][N];
  logic       m_s2   [NDUT][N];
  logic       m_gin  [NDUT][N];
  int         m_run  [NDUT][N];  // cycles the synced input has disagreed with gpio_in

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] tgt_cfg(logic oe, logic pu, logic pd);
    logic oet;
    oet = oe & ~pu & ~pd;
    return {oet, ~oe, ~oet, oe};
  endfunction

  function automatic logic tgt_out(logic o, logic pu, logic pd);
    return pu ? 1'b1 : (pd ? 1'b0 : o);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < N; i++) begin
        m_app[d][i] = SAFE;  m_pend[d][i] = SAFE;  m_show[d][i] = SAFE;
        m_out[d][i] = 1'b0;  m_left[d][i] = 0;     m_run[d][i] = 0;
        m_s1[d][i] = 1'b0;   m_s2[d][i] = 1'b0;    m_gin[d][i] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    logic [3:0] ct;
    logic       ot;
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < N; i++) begin
        ct = tgt_cfg(req_oe[i], req_pu[i], req_pd[i]);
        ot = tgt_out(req_out[i], req_pu[i], req_pd[i]);
        if (m_left[d][i] > 0) begin
          if (ct != m_pend[d][i]) begin
            m_pend[d][i] = ct;
            m_left[d][i] = dead_p[d];
          end else begin
            m_left[d][i]--;
            if (m_left[d][i] == 0) begin
              m_app[d][i] = ct;  m_show[d][i] = ct;  m_out[d][i] = ot;
            end
          end
        end else if (ct == m_app[d][i]) begin
          m_out[d][i] = ot;
        end else if (dead_p[d] == 0 || ct == SAFE) begin
          m_app[d][i] = ct;  m_show[d][i] = ct;  m_out[d][i] = ot;
        end else begin
          m_pend[d][i] = ct;  m_left[d][i] = dead_p[d];
          m_show[d][i] = SAFE;  m_out[d][i] = 1'b0;
        end
        if (deb_p[d] > 0) begin
          if (m_s2[d][i] != m_gin[d][i]) begin
            m_run[d][i]++;
            if (m_run[d][i] == deb_p[d]) begin
              m_gin[d][i] = m_s2[d][i];
              m_run[d][i] = 0;
            end
          end else begin
            m_run[d][i] = 0;
          end
        end
        m_s2[d][i] = m_s1[d][i];
        m_s1[d][i] = req_pin[i];
        if (deb_p[d] == 0) m_gin[d][i] = m_s2[d][i];
      end
    end
  endtask

  task automatic check_dut(int d, logic [N-1:0] o, logic [N-1:0] oe, logic [N-1:0] ie,
                           logic [N-1:0] m1, logic [N-1:0] m0, logic [N-1:0] gi,
                           logic [N-1:0] bz);
    logic [N-1:0] e_o, e_oe, e_ie, e_m1, e_m0, e_gi, e_bz;
    string p;
    p = (d == 0) ? "a" : "b";
    for (int i = 0; i < N; i++) begin
      e_o[i]  = m_out[d][i];
      e_oe[i] = m_show[d][i][3];
      e_ie[i] = m_show[d][i][2];
      e_m1[i] = m_show[d][i][1];
      e_m0[i] = m_show[d][i][0];
      e_gi[i] = m_gin[d][i];
      e_bz[i] = (m_left[d][i] > 0);
    end
    check({p, ".out_pad"}, o, e_o);
    check({p, ".outenb_pad"}, oe, e_oe);
    check({p, ".inenb_pad"}, ie, e_ie);
    check({p, ".mode1_pad"}, m1, e_m1);
    check({p, ".mode0_pad"}, m0, e_m0);
    check({p, ".gpio_in"}, gi, e_gi);
    check({p, ".busy"}, bz, e_bz);
  endtask

  task automatic check_all();
    check_dut(0, if_a.gpio_out_pad, if_a.gpio_outenb_pad, if_a.gpio_inenb_pad,
              if_a.gpio_mode1_pad, if_a.gpio_mode0_pad, if_a.gpio_in, if_a.busy);
    check_dut(1, if_b.gpio_out_pad, if_b.gpio_outenb_pad, if_b.gpio_inenb_pad,
              if_b.gpio_mode1_pad, if_b.gpio_mode0_pad, if_b.gpio_in, if_b.busy);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int busy_cnt;
    int lat;
    logic seen;
    dead_p[0] = 2;  deb_p[0] = 4;
    dead_p[1] = 0;  deb_p[1] = 0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst.out_pad", if_a.gpio_out_pad, '0);
    check("rst.outenb_pad", if_a.gpio_outenb_pad, {N{1'b1}});
    check("rst.inenb_pad", if_a.gpio_inenb_pad, '0);
    check("rst.mode1_pad", if_a.gpio_mode1_pad, '0);
    check("rst.mode0_pad", if_a.gpio_mode0_pad, {N{1'b1}});
    check("rst.busy", if_a.busy, '0);
    check("rst.gpio_in", if_a.gpio_in, '0);
    check_all();
    rst = 1'b0;
    step();

    // ch0 input -> driven output: two cycles of SAFE first
    req_oe[0] = 1'b0;
    req_out[0] = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (if_a.busy[0]) busy_cnt++;
    end
    check("ch0.busy_len", busy_cnt, 2);
    check("ch0.pads", {if_a.gpio_outenb_pad[0], if_a.gpio_inenb_pad[0],
                       if_a.gpio_mode1_pad[0], if_a.gpio_mode0_pad[0],
                       if_a.gpio_out_pad[0]}, 5'b01101);

    // Data-only toggling follows with one cycle latency, no dead time
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      req_out[0] = ~req_out[0];
      step();
      if (if_a.busy[0]) seen = 1'b1;
      check("tog.out_pad", if_a.gpio_out_pad[0], req_out[0]);
    end
    check("tog.busy", seen, 1'b0);

    // ch3: target changes on the last dead cycle, window restarts
    req_oe[3] = 1'b0;
    req_out[3] = 1'b1;
    step();
    step();
    req_oe[3] = 1'b1;
    req_pd[3] = 1'b1;
    step();
    step();
    check("ch3.busy_held", if_a.busy[3], 1'b1);
    check("ch3.safe_held", if_a.gpio_outenb_pad[3], 1'b1);
    step();
    check("ch3.busy_done", if_a.busy[3], 1'b0);
    check("ch3.outenb_pad", if_a.gpio_outenb_pad[3], 1'b0);
    check("ch3.out_pad", if_a.gpio_out_pad[3], 1'b0);

    // ch1 debounce: a 3-cycle pulse is filtered, a long level arrives after 2+4 cycles
    req_pin[1] = 1'b1;
    repeat (3) step();
    req_pin[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (if_a.gpio_in[1]) seen = 1'b1;
    end
    check("deb.short", seen, 1'b0);
    req_pin[1] = 1'b1;
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      if (!if_a.gpio_in[1]) begin
        step();
        lat++;
      end
    end
    check("deb.latency", lat, 6);

    // Asynchronous reset with ch5 in DEAD and ch6 driving
    req_oe[6] = 1'b0;
    req_out[6] = 1'b1;
    repeat (4) step();
    check("arst.ch6_drive", if_a.gpio_out_pad[6], 1'b1);
    req_oe[5] = 1'b0;
    step();
    check("arst.ch5_dead", if_a.busy[5], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst.busy", if_a.busy, '0);
    check("arst.outenb_pad", if_a.gpio_outenb_pad, {N{1'b1}});
    check("arst.out_pad", if_a.gpio_out_pad, '0);
    check("arst.gpio_in", if_a.gpio_in, '0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rel.ch6_busy", if_a.busy[6], 1'b1);
    check("rel.ch6_safe", if_a.gpio_outenb_pad[6], 1'b1);

    // Random phase
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(15) == 0) begin
          req_oe[i] = 1'($urandom_range(1));
          req_pu[i] = ($urandom_range(3) == 0);
          req_pd[i] = ($urandom_range(3) == 0);
        end
        if ($urandom_range(1) == 1) req_out[i] = ~req_out[i];
        if ($urandom_range(9) == 0) req_pin[i] = ~req_pin[i];
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
